seg_pattern_decoder: RTL and testbench

- Receive-side decoder for the one-hot-digit segment encoder: takes the 7-bit segment bus (plus spare bit 7) driven by the encoder and recovers the digit index 0-7.
- Synchronises and filters the bus, then requires a pattern to be stable before decoding it.
- Presents each decoded digit once on a valid/ready handshake.
- Flags and counts patterns that are not in the encoder's table.

---
 rtl/seg_pattern_decoder.sv | 135 +++++++++++++
 tb/tb_seg_pattern_decoder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_pattern_decoder.sv
// Receive-side decoder for the one-hot-digit segment encoder.
// It synchronises the segment bus, waits for a pattern to stay stable, then decodes it once onto a valid/ready handshake.
module seg_pattern_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       seg_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [2:0]       digit_bin,
    output logic [7:0]       digit_onehot,
    output logic             pattern_err,
    output logic [ERR_W-1:0] err_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD,
        WAIT_RELEASE
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(STABLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic [7:0]       sync1_q;
    logic [7:0]       sync2_q;
    logic [7:0]       cand_q;
    logic [3:0]       cnt_q;
    logic             outValid_q;
    logic [2:0]       digitBin_q;
    logic [7:0]       digitOnehot_q;
    logic             patternErr_q;
    logic [ERR_W-1:0] errCount_q;
    logic [ERR_W-1:0] errCount_d;

    logic             tableHit;
    logic [2:0]       tableDigit;

    // Encoder table lookup on the synchronised sample; bit 7 set never matches.
    always_comb begin
        tableHit   = 1'b1;
        tableDigit = 3'd0;
        case (sync2_q)
            8'h06:   tableDigit = 3'd0;
            8'h4B:   tableDigit = 3'd1;
            8'h4D:   tableDigit = 3'd2;
            8'h66:   tableDigit = 3'd3;
            8'h7F:   tableDigit = 3'd4;
            8'h7D:   tableDigit = 3'd5;
            8'h07:   tableDigit = 3'd6;
            8'h6F:   tableDigit = 3'd7;
            default: tableHit   = 1'b0;
        endcase
    end

    always_comb begin
        errCount_d = errCount_q;
        if (errCount_q != '1) begin
            errCount_d = errCount_q + ERR_ONE;
        end
    end

    // Decode FSM: a pattern must repeat STABLE_CYCLES samples before it is decoded or flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            sync1_q       <= 8'h00;
            sync2_q       <= 8'h00;
            cand_q        <= 8'h00;
            cnt_q         <= 4'd0;
            outValid_q    <= 1'b0;
            digitBin_q    <= 3'd0;
            digitOnehot_q <= 8'h00;
            patternErr_q  <= 1'b0;
            errCount_q    <= '0;
        end else begin
            sync1_q      <= seg_in;
            sync2_q      <= sync1_q;
            patternErr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sync2_q != 8'h00) begin
                        cand_q  <= sync2_q;
                        cnt_q   <= 4'd1;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (sync2_q == 8'h00) begin
                        state_q <= IDLE;
                    end else if (sync2_q != cand_q) begin
                        cand_q <= sync2_q;
                        cnt_q  <= 4'd1;
                    end else if (cnt_q < LAST_CNT) begin
                        cnt_q <= cnt_q + 4'd1;
                    end else if (tableHit) begin
                        digitBin_q    <= tableDigit;
                        digitOnehot_q <= 8'h01 << tableDigit;
                        outValid_q    <= 1'b1;
                        state_q       <= HOLD;
                    end else begin
                        patternErr_q <= 1'b1;
                        errCount_q   <= errCount_d;
                        state_q      <= WAIT_RELEASE;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE: begin
                    if (sync2_q == 8'h00) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid    = outValid_q;
    assign digit_bin    = digitBin_q;
    assign digit_onehot = digitOnehot_q;
    assign pattern_err  = patternErr_q;
    assign err_count    = errCount_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Self-checking bench for seg_pattern_decoder.
// It uses directed scenarios plus random bursts, which are scored against an event-level model of decodes and errors.
module tb_seg_pattern_decoder;

    localparam int STABLE = 4;
    localparam int ERR_W  = 8;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic [7:0]       seg_in    = 8'h00;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [2:0]       digit_bin;
    logic [7:0]       digit_onehot;
    logic             pattern_err;
    logic [ERR_W-1:0] err_count;
    logic             busy;

    int checks    = 0;
    int errors    = 0;
    int gotDigits[$];
    int errPulses = 0;
    int overlaps  = 0;
    logic prevValid = 1'b0;

    logic [7:0] tablePat [8] = '{8'h06, 8'h4B, 8'h4D, 8'h66, 8'h7F, 8'h7D, 8'h07, 8'h6F};

    seg_pattern_decoder #(
        .STABLE_CYCLES(STABLE),
        .ERR_W        (ERR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .digit_bin   (digit_bin),
        .digit_onehot(digit_onehot),
        .pattern_err (pattern_err),
        .err_count   (err_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Event monitor: records each new decode, each error pulse, and any valid/error overlap.
    always @(posedge clk) begin
        #1;
        if (out_valid && !prevValid) gotDigits.push_back(int'(digit_bin));
        if (pattern_err) errPulses++;
        if (out_valid && pattern_err) overlaps++;
        prevValid = out_valid;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired before the summary line");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int lookupDigit(input logic [7:0] p);
        for (int i = 0; i < 8; i++) begin
            if (tablePat[i] == p) return i;
        end
        return -1;
    endfunction

    function automatic int digitAt(input int idx);
        if (idx < gotDigits.size()) return gotDigits[idx];
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] seg, input logic rdy, input int cycles);
        @(negedge clk);
        seg_in    = seg;
        out_ready = rdy;
        repeat (cycles) @(posedge clk);
    endtask

    task automatic waitValid(input string tag, input int budget);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        checkOutput(tag, 32'(out_valid), 32'd1);
    endtask

    task automatic checkAllClear(input string tag);
        checkOutput({tag, "_valid"},  32'(out_valid),    32'd0);
        checkOutput({tag, "_bin"},    32'(digit_bin),    32'd0);
        checkOutput({tag, "_onehot"}, 32'(digit_onehot), 32'd0);
        checkOutput({tag, "_perr"},   32'(pattern_err),  32'd0);
        checkOutput({tag, "_errcnt"}, 32'(err_count),    32'd0);
        checkOutput({tag, "_busy"},   32'(busy),         32'd0);
    endtask

    initial begin
        int base;
        int errBase;
        int expErr;
        int expDigits[$];
        logic [7:0] p;
        int len;
        int gap;
        int d;

        #1;
        checkAllClear("reset");
        #20;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'h00, 1'b1, 3);

        // Latency: the pattern is decoded at the sixth edge and only once while it is held.
        base = gotDigits.size();
        @(negedge clk);
        seg_in    = 8'h4D;
        out_ready = 1'b1;
        repeat (STABLE + 1) @(posedge clk);
        #2;
        checkOutput("lat_not_early", 32'(out_valid), 32'd0);
        @(posedge clk);
        #2;
        checkOutput("lat_valid",  32'(out_valid),    32'd1);
        checkOutput("lat_bin",    32'(digit_bin),    32'd2);
        checkOutput("lat_onehot", 32'(digit_onehot), 32'h04);
        repeat (20) @(posedge clk);
        #2;
        checkOutput("held_once",       32'(gotDigits.size() - base), 32'd1);
        checkOutput("held_valid_low",  32'(out_valid),               32'd0);
        checkOutput("held_busy",       32'(busy),                    32'd1);
        applyStimulus(8'h00, 1'b1, 4);
        #2;
        checkOutput("release_idle", 32'(busy), 32'd0);

        // Every table digit in order.
        base = gotDigits.size();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(tablePat[i], 1'b1, STABLE + 3);
            applyStimulus(8'h00, 1'b1, 3);
        end
        checkOutput("seq_count", 32'(gotDigits.size() - base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("seq_digit%0d", i), 32'(digitAt(base + i)), 32'(i));
        end
        checkOutput("seq_errcnt", 32'(err_count), 32'd0);

        // A short burst just below the stability threshold must not be decoded.
        base = gotDigits.size();
        applyStimulus(8'h7F, 1'b1, STABLE - 1);
        applyStimulus(8'h6F, 1'b1, 10);
        applyStimulus(8'h00, 1'b1, 4);
        checkOutput("glitch_count", 32'(gotDigits.size() - base), 32'd1);
        checkOutput("glitch_digit", 32'(digitAt(base)),           32'd7);

        // Random bursts are scored against the expected stream of decodes and error pulses.
        base    = gotDigits.size();
        errBase = errPulses;
        expErr  = 0;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) < 2) p = tablePat[$urandom_range(0, 7)];
            else                          p = 8'($urandom_range(1, 255));
            len = $urandom_range(1, 8);
            gap = $urandom_range(2, 4);
            if (len >= STABLE) begin
                d = lookupDigit(p);
                if (d >= 0) expDigits.push_back(d);
                else        expErr++;
            end
            applyStimulus(p, 1'b1, len);
            applyStimulus(8'h00, 1'b1, gap);
        end
        checkOutput("rand_count", 32'(gotDigits.size() - base), 32'(expDigits.size()));
        foreach (expDigits[i]) begin
            checkOutput($sformatf("rand_digit%0d", i), 32'(digitAt(base + i)), 32'(expDigits[i]));
        end
        checkOutput("rand_err_pulses", 32'(errPulses - errBase), 32'(expErr));
        checkOutput("rand_err_count",  32'(err_count),           32'(expErr));

        // Error counter saturation.
        base    = gotDigits.size();
        errBase = errPulses;
        repeat (300) begin
            applyStimulus(8'h55, 1'b1, STABLE + 2);
            applyStimulus(8'h00, 1'b1, 3);
        end
        checkOutput("sat_pulses",    32'(errPulses - errBase),      32'd300);
        checkOutput("sat_no_decode", 32'(gotDigits.size() - base),  32'd0);
        checkOutput("sat_count",     32'(err_count),                32'hFF);

        // Back-pressure: the decoded digit is held and the bus is ignored until the handshake.
        base = gotDigits.size();
        applyStimulus(8'h66, 1'b0, 1);
        waitValid("bp_wait_valid", 20);
        checkOutput("bp_bin", 32'(digit_bin), 32'd3);
        applyStimulus(8'h06, 1'b0, 10);
        #2;
        checkOutput("bp_still_valid", 32'(out_valid),    32'd1);
        checkOutput("bp_still_bin",   32'(digit_bin),    32'd3);
        checkOutput("bp_onehot",      32'(digit_onehot), 32'h08);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("bp_handshake_clear", 32'(out_valid), 32'd0);
        checkOutput("bp_bin_kept",        32'(digit_bin), 32'd3);
        applyStimulus(8'h06, 1'b1, 10);
        checkOutput("bp_no_redecode", 32'(gotDigits.size() - base), 32'd1);
        applyStimulus(8'h00, 1'b1, 3);
        applyStimulus(8'h06, 1'b1, STABLE + 3);
        checkOutput("bp_redecode_count", 32'(gotDigits.size() - base), 32'd2);
        checkOutput("bp_redecode_digit", 32'(digitAt(base + 1)),       32'd0);
        applyStimulus(8'h00, 1'b1, 3);

        // Asynchronous reset in SETTLE.
        applyStimulus(8'h4B, 1'b1, 4);
        #2;
        checkOutput("pre_rst_busy", 32'(busy), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        checkAllClear("rst_settle");
        @(negedge clk);
        seg_in = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset in HOLD.
        applyStimulus(8'h00, 1'b0, 2);
        applyStimulus(8'h4B, 1'b0, 1);
        waitValid("rst_hold_wait_valid", 20);
        checkOutput("rst_hold_bin", 32'(digit_bin), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkAllClear("rst_hold");
        @(negedge clk);
        seg_in    = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'h00, 1'b1, 2);

        // Normal latency after reset release.
        @(negedge clk);
        seg_in = 8'h07;
        repeat (STABLE + 1) @(posedge clk);
        #2;
        checkOutput("post_rst_not_early", 32'(out_valid), 32'd0);
        @(posedge clk);
        #2;
        checkOutput("post_rst_valid",  32'(out_valid),    32'd1);
        checkOutput("post_rst_bin",    32'(digit_bin),    32'd6);
        checkOutput("post_rst_onehot", 32'(digit_onehot), 32'h40);
        applyStimulus(8'h00, 1'b1, 4);

        checkOutput("no_overlap", 32'(overlaps), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
